spi_reg_ctrl: RTL

- Command sequencer and bus arbiter behind the 16-bit SPI slave shifter on the ice40. The SAMD51 host talks to it over SPI.
- Decodes host frames (one command word, then data words) into register-bus reads and writes, with optional address auto-increment.
- Shares the single register bus between the SPI host and one local fabric requester using round-robin arbitration.
- Enforces a bus timeout and keeps sticky error flags.

---
 rtl/spi_reg_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI frame sequencer and register-bus arbiter: decodes host command/data words into
// bus reads/writes and shares the bus round-robin with one local fabric requester.
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [15:0] ERR_WORD = 16'hDEAD
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frm_start,
  input  logic              frm_end,
  input  logic              rx_valid,
  input  logic [15:0]       rx_word,
  output logic [15:0]       tx_word,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [15:0]       loc_wdata,
  output logic              loc_ack,
  output logic [15:0]       loc_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [15:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [15:0]       bus_rdata,
  output logic [2:0]        err_status,
  input  logic              err_clr
);

  typedef enum logic [1:0] {F_IDLE, F_CMD, F_WR, F_RD} fstate_t;
  typedef enum logic [1:0] {B_IDLE, B_SPI, B_LOC} bstate_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  fstate_t r_fstate, w_fnext;
  bstate_t r_bstate, w_bnext;

  logic [ADDR_W-1:0] r_addr, r_slot_addr, w_addr_nxt, w_cmd_addr;
  logic              r_ainc, r_slot_v, r_slot_we, r_spi_busy, r_tx_ready, r_last_loc;
  logic [15:0]       r_slot_data, r_tcnt, w_rdata;
  logic              w_rx_live, w_occupied, w_cmd, w_wr_load, w_rd_next;
  logic              w_overrun, w_underrun;
  logic              w_spi_pend, w_loc_pend, w_grant_spi, w_grant_loc;
  logic              w_busy, w_tout, w_done, w_spi_done, w_tx_upd;

  // Frame decode; a word coinciding with a frame boundary belongs to neither frame
  assign w_rx_live  = rx_valid && !frm_start && !frm_end;
  assign w_occupied = r_slot_v || r_spi_busy;
  assign w_cmd_addr = rx_word[ADDR_W-1:0];
  assign w_addr_nxt = r_addr + ADDR_W'(r_ainc);
  assign w_cmd      = w_rx_live && (r_fstate == F_CMD);
  assign w_wr_load  = w_rx_live && (r_fstate == F_WR) && !w_occupied;
  assign w_overrun  = w_rx_live && (r_fstate == F_WR) && w_occupied;
  assign w_underrun = w_rx_live && (r_fstate == F_RD) && !r_tx_ready && w_occupied;
  assign w_rd_next  = w_rx_live && (r_fstate == F_RD) && !w_underrun;

  // Bus completion and arbitration
  assign w_busy      = (r_bstate != B_IDLE);
  assign w_tout      = w_busy && !bus_ack && (r_tcnt == TO_LAST);
  assign w_done      = w_busy && (bus_ack || w_tout);
  assign w_rdata     = bus_ack ? bus_rdata : ERR_WORD;
  assign w_spi_done  = (r_bstate == B_SPI) && w_done;
  assign w_spi_pend  = r_slot_v;
  assign w_loc_pend  = loc_req && !loc_ack;
  assign w_grant_spi = (r_bstate == B_IDLE) && w_spi_pend && (!w_loc_pend || r_last_loc);
  assign w_grant_loc = (r_bstate == B_IDLE) && w_loc_pend && (!w_spi_pend || !r_last_loc);
  // Read data is kept only for a live cycle of the frame that is still reading
  assign w_tx_upd    = w_spi_done && r_spi_busy && !bus_we && (r_fstate == F_RD) &&
                       !frm_start && !frm_end;

  always_comb begin
    w_fnext = r_fstate;
    if (frm_end)        w_fnext = F_IDLE;
    else if (frm_start) w_fnext = F_CMD;
    else if (w_cmd)     w_fnext = rx_word[15] ? F_WR : F_RD;
  end

  always_comb begin
    w_bnext = r_bstate;
    case (r_bstate)
      B_IDLE: begin
        if (w_grant_spi)      w_bnext = B_SPI;
        else if (w_grant_loc) w_bnext = B_LOC;
      end
      default: if (w_done) w_bnext = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fstate    <= F_IDLE;
      r_addr      <= '0;
      r_ainc      <= 1'b0;
      r_slot_v    <= 1'b0;
      r_slot_we   <= 1'b0;
      r_slot_addr <= '0;
      r_slot_data <= '0;
      r_spi_busy  <= 1'b0;
      r_tx_ready  <= 1'b0;
      tx_word     <= '0;
      err_status  <= '0;
    end else begin
      r_fstate   <= w_fnext;
      err_status <= (err_clr ? '0 : err_status) | {w_tout, w_underrun, w_overrun};
      if (w_spi_done) r_spi_busy <= 1'b0;
      if (w_grant_spi) begin
        r_slot_v   <= 1'b0;
        r_spi_busy <= 1'b1;
      end
      if (w_tx_upd) begin
        tx_word    <= w_rdata;
        r_tx_ready <= 1'b1;
      end
      // A restarted frame disowns both the pending slot and any in-flight SPI cycle
      if (frm_start) begin
        r_slot_v   <= 1'b0;
        r_spi_busy <= 1'b0;
        r_tx_ready <= 1'b0;
      end else if (w_cmd) begin
        r_addr     <= w_cmd_addr;
        r_ainc     <= rx_word[14];
        r_tx_ready <= 1'b0;
        if (!rx_word[15]) begin
          r_slot_v    <= 1'b1;
          r_slot_we   <= 1'b0;
          r_slot_addr <= w_cmd_addr;
        end
      end else if (w_wr_load) begin
        r_slot_v    <= 1'b1;
        r_slot_we   <= 1'b1;
        r_slot_addr <= r_addr;
        r_slot_data <= rx_word;
        r_addr      <= w_addr_nxt;
      end else if (w_rd_next) begin
        r_slot_v    <= 1'b1;
        r_slot_we   <= 1'b0;
        r_slot_addr <= w_addr_nxt;
        r_addr      <= w_addr_nxt;
        r_tx_ready  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bstate   <= B_IDLE;
      r_last_loc <= 1'b1;
      r_tcnt     <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      loc_ack    <= 1'b0;
      loc_rdata  <= '0;
    end else begin
      r_bstate <= w_bnext;
      loc_ack  <= 1'b0;
      if (w_grant_spi) begin
        bus_req    <= 1'b1;
        bus_we     <= r_slot_we;
        bus_addr   <= r_slot_addr;
        bus_wdata  <= r_slot_data;
        r_last_loc <= 1'b0;
        r_tcnt     <= '0;
      end else if (w_grant_loc) begin
        bus_req    <= 1'b1;
        bus_we     <= loc_we;
        bus_addr   <= loc_addr;
        bus_wdata  <= loc_wdata;
        r_last_loc <= 1'b1;
        r_tcnt     <= '0;
      end else if (w_busy) begin
        if (w_done) bus_req <= 1'b0;
        else        r_tcnt  <= r_tcnt + 16'd1;
      end
      if ((r_bstate == B_LOC) && w_done) begin
        loc_ack   <= 1'b1;
        loc_rdata <= w_rdata;
      end
    end
  end

endmodule
